herculesae_vx_ghash_red: RTL
============================

# herculesae_vx_ghash_red

Downstream consumer of the 64x64 carry-less multiplier stage. It collects the three Karatsuba partial products (LO, HI, MID) of a 128x128 GF(2) multiply, one per valid multiplier result. It then combines them into a 255-bit product and reduces that product modulo x^128 + x^7 + x^2 + x + 1. It sits between the multiplier output register and the vector writeback mux, giving a registered 128-bit field product for GHASH/GCM sequences.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- clk  in  1  core clock.
- reset  in  1  reset; synchronous, active-high. Clears all state on the clk edge where it is sampled high.
- pval_v2  in  1  a partial product is presented this cycle.
- ptype_v2  in  2  tag for pdata_v2:
  - 2'b00 = LO = a0*b0
  - 2'b01 = HI = a1*b1
  - 2'b10 = MID = (a0^a1)*(b0^b1)
  - 2'b11 = illegal
- pdata_v2  in  128  partial product. Bit 127 is always 0 for 64x64 products and is still used as given.
- flush_v2  in  1  abandons any partial sequence.
- ghash_vld_v3_q  out  1  result valid, one-cycle pulse.
- ghash_out_v3_q  out  128  reduced product, plain polynomial bit order with bit i = coefficient of x^i. Holds its value until the next result.
- seq_err_v3_q  out  1  one-cycle pulse on a protocol violation.
- busy_v2  out  1  high when the state is not IDLE.

## Operation
- Sequence order is fixed: LO, then HI, then MID. Any number of idle cycles is allowed between beats.
- Holding registers:
  - lo_q[127:0] is written on an accepted LO.
  - hi_q[127:0] is written on an accepted HI.
  - mid_q[127:0] is written on an accepted MID.
- State machine: IDLE, GOT_LO, GOT_HI, RED.
  - IDLE: LO goes to GOT_LO. HI, MID or illegal gives an error and stays in IDLE.
  - GOT_LO: HI goes to GOT_HI. A new LO overwrites lo_q and stays in GOT_LO with an error pulse. MID or illegal gives an error and goes to IDLE.
  - GOT_HI: MID goes to RED. LO gives an error, restarts and goes to GOT_LO. HI or illegal gives an error and goes to IDLE.
  - RED: lasts one cycle and computes the result. A beat arriving in the same cycle is handled exactly as in IDLE, so LO goes to GOT_LO. This allows back-to-back sequences.
- Combine: P[254:0] = (hi_q << 128) ^ ((mid_q ^ lo_q ^ hi_q) << 64) ^ lo_q.
- Reduce with r = x^7 + x^2 + x + 1:
  - T = P[254:128] * r, which is 134 bits.
  - U = T[133:128] * r.
  - result = P[127:0] ^ T[127:0] ^ U[127:0].
- The reduce is registered into ghash_out_v3_q at the end of RED, and ghash_vld_v3_q is set for one cycle.
- flush_v2 forces the state to IDLE and has priority over pval_v2 in the same cycle.
  - flush never produces an error.
  - flush during RED does not cancel that cycle's result.
- Reset clears the state to IDLE and clears all holding registers. Reset mid-sequence discards the sequence and gives no result.

## Timing
- Reset values: ghash_vld_v3_q=0, ghash_out_v3_q=0, seq_err_v3_q=0, busy_v2=0.
- If MID is accepted at edge N, the state is RED in cycle N+1 and ghash_vld_v3_q is high in cycle N+2 (the cycle after the N+1 edge).
- seq_err_v3_q is high in the cycle after the offending beat.
- Peak throughput is one result per 3 cycles: LO, HI, MID, then the next LO in the RED cycle.
- pval_v2 is never back-pressured. Beats that are not accepted are dropped and flagged with seq_err_v3_q.
- busy_v2 is combinational from the state register.

## Test plan
- LO=1, HI=0, MID=1 -> ghash_out_v3_q=128'h1, vld pulses 2 cycles after the MID beat.
- LO=0, HI=1, MID=1 (P=x^128) -> ghash_out_v3_q=128'h87.
- LO=0, HI=128'h8000_0000_0000_0000_0000_0000_0000_0000, MID=HI (P=x^255) -> ghash_out_v3_q=128'h8000_0000_0000_0000_0000_0000_0000_2049.
- LO=HI=0, MID=1 -> ghash_out_v3_q=128'h0000_0000_0000_0001_0000_0000_0000_0000.
- Two sequences back-to-back (second LO in the RED cycle) -> two vld pulses 3 cycles apart, correct values, no error.
- Protocol and reset cases:
  - HI while in IDLE -> seq_err pulse, no vld.
  - LO,HI then flush then MID -> seq_err, no vld.
  - Reset asserted after HI -> all outputs 0, a following MID gives seq_err.

Source files
------------

// File: rtl/herculesae_vx_ghash_red.sv
// GHASH reduction stage: gathers Karatsuba LO/HI/MID partial products and
// reduces the 256-bit carry-less product modulo x^128 + x^7 + x^2 + x + 1.
module herculesae_vx_ghash_red (
  input  logic         clk,
  input  logic         reset,
  input  logic         pval_v2,
  input  logic [1:0]   ptype_v2,
  input  logic [127:0] pdata_v2,
  input  logic         flush_v2,
  output logic         ghash_vld_v3_q,
  output logic [127:0] ghash_out_v3_q,
  output logic         seq_err_v3_q,
  output logic         busy_v2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GOT_LO,
    S_GOT_HI,
    S_RED
  } state_e;

  localparam logic [1:0] T_LO  = 2'b00;
  localparam logic [1:0] T_HI  = 2'b01;
  localparam logic [1:0] T_MID = 2'b10;

  state_e       state_q, state_d;
  logic [127:0] lo_q, hi_q, mid_q;
  logic         lo_we, hi_we, mid_we;
  logic         err_d;

  logic [255:0] p;
  logic [134:0] t_in, t;
  logic [127:0] u_in, u;
  logic [127:0] red;

  always_comb begin
    state_d = state_q;
    lo_we   = 1'b0;
    hi_we   = 1'b0;
    mid_we  = 1'b0;
    err_d   = 1'b0;
    if (flush_v2) begin
      state_d = S_IDLE;
    end else if (pval_v2) begin
      unique case (state_q)
        S_IDLE, S_RED: begin
          if (ptype_v2 == T_LO) begin
            lo_we   = 1'b1;
            state_d = S_GOT_LO;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_GOT_LO: begin
          if (ptype_v2 == T_HI) begin
            hi_we   = 1'b1;
            state_d = S_GOT_HI;
          end else if (ptype_v2 == T_LO) begin
            lo_we   = 1'b1;
            err_d   = 1'b1;
            state_d = S_GOT_LO;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_GOT_HI: begin
          if (ptype_v2 == T_MID) begin
            mid_we  = 1'b1;
            state_d = S_RED;
          end else if (ptype_v2 == T_LO) begin
            lo_we   = 1'b1;
            err_d   = 1'b1;
            state_d = S_GOT_LO;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_RED) begin
      state_d = S_IDLE;
    end
  end

  // Bit 127 of HI reaches x^255, so the product is kept at 256 bits.
  always_comb begin
    p = {hi_q, 128'b0}
      ^ ({128'b0, mid_q ^ lo_q ^ hi_q} << 64)
      ^ {128'b0, lo_q};
    t_in = {7'b0, p[255:128]};
    t    = t_in ^ (t_in << 1) ^ (t_in << 2) ^ (t_in << 7);
    u_in = {121'b0, t[134:128]};
    u    = u_in ^ (u_in << 1) ^ (u_in << 2) ^ (u_in << 7);
    red  = p[127:0] ^ t[127:0] ^ u;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      lo_q           <= '0;
      hi_q           <= '0;
      mid_q          <= '0;
      ghash_vld_v3_q <= 1'b0;
      ghash_out_v3_q <= '0;
      seq_err_v3_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      if (lo_we)  lo_q  <= pdata_v2;
      if (hi_we)  hi_q  <= pdata_v2;
      if (mid_we) mid_q <= pdata_v2;
      ghash_vld_v3_q <= (state_q == S_RED);
      if (state_q == S_RED) ghash_out_v3_q <= red;
      seq_err_v3_q   <= err_d;
    end
  end

  assign busy_v2 = (state_q != S_IDLE);

endmodule
